// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction-fetch stage: PC ownership, req/ack memory fetch, jump/branch redirect
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   imemReq, imemAddr           fetch request (held until imemAck) and word-aligned byte address
//   imemAck, imemData           memory accept strobe and fetched word (valid with imemAck)
//   stall                       downstream hold: keep the current instruction presented
//   jumpMux, jumpNextAddr       jump redirect and target (highest priority)
//   branchTaken, branchTarget   qualified branch redirect and target
//   instrValid                  instruction/opcode/funct/pcOut valid
//   instruction, opcode, funct  current word and its [31:26] / [5:0] fields
//   pcOut                       byte address of the current instruction
//   addrErr                     one-cycle pulse when a redirect target was misaligned
//   fetchCount, stallCycles     performance counters, present only with IFETCH_PERF_EN
//
// Optional feature macro: IFETCH_PERF_EN

module instr_fetch #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [31:0]       imemData,
    input  logic              stall,
    input  logic              jumpMux,
    input  logic [ADDR_W-1:0] jumpNextAddr,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic              instrValid,
    output logic [31:0]       instruction,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pcOut,
`ifdef IFETCH_PERF_EN
    output logic [31:0]       fetchCount,
    output logic [31:0]       stallCycles,
`endif
    output logic              addrErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              pending;
    logic [ADDR_W-1:0] pend_target;

    // Redirect decode shared by the REQ and VALID states. Jump wins over
    // branch; a misaligned target is truncated to a word boundary and flagged.
    logic              redir_now;
    logic [ADDR_W-1:0] redir_raw;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_mis;
    logic [ADDR_W-1:0] pc_seq;

    assign redir_now = jumpMux | branchTaken;
    assign redir_raw = jumpMux ? jumpNextAddr : branchTarget;
    assign redir_tgt = {redir_raw[ADDR_W-1:2], 2'b00};
    assign redir_mis = redir_now && (redir_raw[1:0] != 2'b00);
    // Sequential successor; wraps naturally at 2^ADDR_W.
    assign pc_seq    = pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imemReq     <= 1'b0;
            imemAddr    <= RESET_PC;
            instrValid  <= 1'b0;
            instruction <= 32'h0;
            opcode      <= 6'h0;
            funct       <= 6'h0;
            pcOut       <= RESET_PC;
            addrErr     <= 1'b0;
            pending     <= 1'b0;
            pend_target <= RESET_PC;
`ifdef IFETCH_PERF_EN
            fetchCount  <= 32'h0;
            stallCycles <= 32'h0;
`endif
        end else begin
            addrErr <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imemReq  <= 1'b1;
                    imemAddr <= pc;
                end

                REQ: begin
                    if (redir_now) begin
                        addrErr <= redir_mis;
                    end
                    if (imemAck) begin
                        if (pending || redir_now) begin
                            // The word in flight belongs to the old path: drop it
                            // and re-request at the redirect target. A redirect
                            // arriving with the ack is the newest and wins.
                            pc       <= redir_now ? redir_tgt : pend_target;
                            imemAddr <= redir_now ? redir_tgt : pend_target;
                            pending  <= 1'b0;
                            imemReq  <= 1'b1;
                        end else begin
                            instruction <= imemData;
                            opcode      <= imemData[31:26];
                            funct       <= imemData[5:0];
                            pcOut       <= pc;
                            instrValid  <= 1'b1;
                            imemReq     <= 1'b0;
                            state       <= VALID;
`ifdef IFETCH_PERF_EN
                            fetchCount  <= fetchCount + 32'd1;
`endif
                        end
                    end else if (redir_now) begin
                        // Keep the current request stable; remember the newest target.
                        pending     <= 1'b1;
                        pend_target <= redir_tgt;
                    end
                end

                VALID: begin
                    if (stall) begin
`ifdef IFETCH_PERF_EN
                        stallCycles <= stallCycles + 32'd1;
`endif
                    end else begin
                        pc         <= redir_now ? redir_tgt : pc_seq;
                        imemAddr   <= redir_now ? redir_tgt : pc_seq;
                        addrErr    <= redir_mis;
                        imemReq    <= 1'b1;
                        instrValid <= 1'b0;
                        state      <= REQ;
                    end
                end

                default: begin
                    state      <= IDLE;
                    imemReq    <= 1'b0;
                    instrValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stall;
    logic        jumpMux;
    logic [31:0] jumpNextAddr;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        instrValid;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pcOut;
    logic        addrErr;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCycles;
`endif

    int checks = 0;
    int errors = 0;

    int unsigned ack_wait = 0;
    int unsigned wcnt = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .stall        (stall),
        .jumpMux      (jumpMux),
        .jumpNextAddr (jumpNextAddr),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .instrValid   (instrValid),
        .instruction  (instruction),
        .opcode       (opcode),
        .funct        (funct),
        .pcOut        (pcOut),
`ifdef IFETCH_PERF_EN
        .fetchCount   (fetchCount),
        .stallCycles  (stallCycles),
`endif
        .addrErr      (addrErr)
    );

    // Memory model: word at 0 is the reference instruction, others are address-tagged.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h20010005 : (a ^ 32'h5A5A0000);
    endfunction

    assign imemData = mem_word(imemAddr);
    assign imemAck  = imemReq && (wcnt >= ack_wait);

    // Counts request cycles without an ack to insert memory wait states.
    always @(posedge clk) begin
        if (imemReq && !imemAck) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; jumpMux = 1'b0; branchTaken = 1'b0;
        jumpNextAddr = 32'h0; branchTarget = 32'h0;
        #1;
        chk("rst_req",   {31'h0, imemReq}, 32'h0);
        chk("rst_valid", {31'h0, instrValid}, 32'h0);
        chk("rst_addr",  imemAddr, 32'h0);
        chk("rst_pcout", pcOut, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_aerr",  {31'h0, addrErr}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // First fetch with zero-wait memory
        tick();
        chk("f0_req",   {31'h0, imemReq}, 32'h1);
        chk("f0_addr",  imemAddr, 32'h0);
        chk("f0_vld0",  {31'h0, instrValid}, 32'h0);
        tick();
        chk("f0_vld",   {31'h0, instrValid}, 32'h1);
        chk("f0_instr", instruction, 32'h20010005);
        chk("f0_opc",   {26'h0, opcode}, 32'h08);
        chk("f0_fun",   {26'h0, funct}, 32'h05);
        chk("f0_pc",    pcOut, 32'h0);
        chk("f0_req0",  {31'h0, imemReq}, 32'h0);

        // Sequential fetches
        tick();
        chk("f1_addr",  imemAddr, 32'h4);
        chk("f1_vld0",  {31'h0, instrValid}, 32'h0);
        tick();
        chk("f1_vld",   {31'h0, instrValid}, 32'h1);
        chk("f1_pc",    pcOut, 32'h4);
        chk("f1_opc",   {26'h0, opcode}, 32'h16);
        chk("f1_fun",   {26'h0, funct}, 32'h04);
        tick();
        chk("f2_addr",  imemAddr, 32'h8);
        tick();
        chk("f2_pc",    pcOut, 32'h8);
        chk("f2_instr", instruction, 32'h5A5A0008);

        // Jump from VALID
        jumpMux = 1'b1; jumpNextAddr = 32'h40;
        tick();
        jumpMux = 1'b0;
        chk("jmp_addr", imemAddr, 32'h40);
        chk("jmp_aerr", {31'h0, addrErr}, 32'h0);
        tick();
        chk("jmp_pc",   pcOut, 32'h40);

        // Jump and branch together: jump wins
        jumpMux = 1'b1; jumpNextAddr = 32'h40; branchTaken = 1'b1; branchTarget = 32'h80;
        ack_wait = 3;
        tick();
        jumpMux = 1'b0; branchTaken = 1'b0;
        chk("pri_addr", imemAddr, 32'h40);

        // Branch during REQ, ack 3 cycles late: fetched word discarded
        branchTaken = 1'b1; branchTarget = 32'h100;
        tick();
        branchTaken = 1'b0;
        chk("pend_addr", imemAddr, 32'h40);
        chk("pend_req",  {31'h0, imemReq}, 32'h1);
        tick();
        chk("pend_vld1", {31'h0, instrValid}, 32'h0);
        tick();
        chk("pend_vld2", {31'h0, instrValid}, 32'h0);
        tick();
        chk("disc_vld",  {31'h0, instrValid}, 32'h0);
        chk("disc_addr", imemAddr, 32'h100);
        chk("disc_req",  {31'h0, imemReq}, 32'h1);
        ack_wait = 0;
        tick();
        chk("br_vld",   {31'h0, instrValid}, 32'h1);
        chk("br_pc",    pcOut, 32'h100);
        chk("br_instr", instruction, 32'h5A5A0100);

        // Stall for 5 cycles in VALID
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stl_vld", {31'h0, instrValid}, 32'h1);
            chk("stl_pc",  pcOut, 32'h100);
            chk("stl_req", {31'h0, imemReq}, 32'h0);
            chk("stl_ins", instruction, 32'h5A5A0100);
        end
`ifdef IFETCH_PERF_EN
        chk("perf_stall", stallCycles, 32'd5);
        chk("perf_fetch", fetchCount, 32'd5);
`endif
        stall = 1'b0;
        tick();
        chk("post_stl_addr", imemAddr, 32'h104);
        tick();
        chk("post_stl_pc", pcOut, 32'h104);

        // Wrap of pc+4
        jumpMux = 1'b1; jumpNextAddr = 32'hFFFFFFFC;
        tick();
        jumpMux = 1'b0;
        chk("wr_addr", imemAddr, 32'hFFFFFFFC);
        tick();
        chk("wr_pc",   pcOut, 32'hFFFFFFFC);
        tick();
        chk("wrap_addr", imemAddr, 32'h0);
        chk("wrap_aerr", {31'h0, addrErr}, 32'h0);
        tick();
        chk("wrap_pc", pcOut, 32'h0);

        // Misaligned branch target
        branchTaken = 1'b1; branchTarget = 32'h42;
        tick();
        branchTaken = 1'b0;
        chk("mis_addr", imemAddr, 32'h40);
        chk("mis_aerr", {31'h0, addrErr}, 32'h1);
        tick();
        chk("mis_aerr0", {31'h0, addrErr}, 32'h0);
        chk("mis_pc",    pcOut, 32'h40);

        // Reset in the middle of a request
        ack_wait = 3;
        tick();
        chk("mr_req",  {31'h0, imemReq}, 32'h1);
        chk("mr_addr", imemAddr, 32'h44);
        rst_n = 1'b0;
        #1;
        chk("mr_req0",  {31'h0, imemReq}, 32'h0);
        chk("mr_addr0", imemAddr, 32'h0);
        chk("mr_vld0",  {31'h0, instrValid}, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("mr_perf",  fetchCount, 32'd0);
`endif
        ack_wait = 0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rr_addr", imemAddr, 32'h0);
        chk("rr_req",  {31'h0, imemReq}, 32'h1);
        tick();
        chk("rr_instr", instruction, 32'h20010005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
